// File: rtl/uarc_link_pkg.sv
// -----------------------------------------------------------------------------
// uarc_link_pkg
// Shared types for the UARC link stage:
//   link_state_t : control FSM states (kill / incept serialisation)
//   link_entry_t : one buffered send/stream word plus its self_* payload
// LINK_WORD_MAG / LINK_WORD_WIDTH set the word width of link_entry_t; the
// uarc_link WORD_MAG parameter defaults to LINK_WORD_MAG and must track it.
// -----------------------------------------------------------------------------
package uarc_link_pkg;

    localparam int unsigned LINK_WORD_MAG   = 5;
    localparam int unsigned LINK_WORD_WIDTH = 1 << LINK_WORD_MAG;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        KILL_WAIT,
        KILL_DONE,
        INCEPT_WAIT,
        INCEPT_DONE
    } link_state_t;

    typedef struct packed {
        logic                       is_stream;
        logic [LINK_WORD_WIDTH-1:0] data;
        logic [LINK_WORD_WIDTH-1:0] self_permission;
        logic [LINK_WORD_WIDTH-1:0] self_address;
    } link_entry_t;

endpackage

// File: rtl/uarc_link_fifo.sv
// -----------------------------------------------------------------------------
// uarc_link_fifo
// Synchronous FIFO of link_entry_t, depth 1 << ADDR_WIDTH.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   push_i        : write push_entry_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO; wins over push and pop
//   full_o/empty_o: occupancy flags
//   head_o        : entry at the head (meaningful only when !empty_o)
// -----------------------------------------------------------------------------
module uarc_link_fifo
    import uarc_link_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  link_entry_t push_entry_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic        full_o,
    output logic        empty_o,
    output link_entry_t head_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    link_entry_t         mem_q [DEPTH];
    // One extra pointer bit: equal pointers mean empty, equal low bits with
    // differing top bits mean full.
    logic [ADDR_WIDTH:0] wr_ptr_q;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (ADDR_WIDTH+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (ADDR_WIDTH+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and resetting memory costs logic.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/uarc_link.sv
// -----------------------------------------------------------------------------
// uarc_link
// One-bus UARC interconnect stage between a sender core and a receiver core.
// Send/stream words are buffered in a small FIFO; kill and incept are
// serialised by a control FSM.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   s_enable                   : sender enable for this bus
//   s_kill/s_incept/s_send/s_stream        : sender requests
//   s_data, s_self_*, s_incept_*           : sender payload
//   s_*_ack                    : acks to sender (send/stream combinational,
//                                kill/incept one-cycle pulses from state)
//   r_enable                   : receiver enable, high while presenting
//   r_kill/r_incept/r_send/r_stream        : requests to receiver
//   r_data, r_self_*, r_incept_*           : payload to receiver (0 when idle)
//   r_*_ack                    : acks from receiver
// -----------------------------------------------------------------------------
module uarc_link
    import uarc_link_pkg::*;
#(
    parameter  int unsigned WORD_MAG        = LINK_WORD_MAG,
    parameter  int unsigned FIFO_ADDR_WIDTH = 2,
    localparam int unsigned WORD_WIDTH      = 1 << WORD_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_enable,
    input  logic                  s_kill,
    input  logic                  s_incept,
    input  logic                  s_send,
    input  logic                  s_stream,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic [WORD_WIDTH-1:0] s_self_permission,
    input  logic [WORD_WIDTH-1:0] s_self_address,
    input  logic [WORD_WIDTH-1:0] s_incept_permission,
    input  logic [WORD_WIDTH-1:0] s_incept_address,
    output logic                  s_kill_ack,
    output logic                  s_incept_ack,
    output logic                  s_send_ack,
    output logic                  s_stream_ack,
    output logic                  r_enable,
    output logic                  r_kill,
    output logic                  r_incept,
    output logic                  r_send,
    output logic                  r_stream,
    output logic [WORD_WIDTH-1:0] r_data,
    output logic [WORD_WIDTH-1:0] r_self_permission,
    output logic [WORD_WIDTH-1:0] r_self_address,
    output logic [WORD_WIDTH-1:0] r_incept_permission,
    output logic [WORD_WIDTH-1:0] r_incept_address,
    input  logic                  r_kill_ack,
    input  logic                  r_incept_ack,
    input  logic                  r_send_ack,
    input  logic                  r_stream_ack
);

    link_state_t           state_q;
    logic [WORD_WIDTH-1:0] cap_self_perm_q;
    logic [WORD_WIDTH-1:0] cap_self_addr_q;
    logic [WORD_WIDTH-1:0] cap_inc_perm_q;
    logic [WORD_WIDTH-1:0] cap_inc_addr_q;

    logic        fifo_full;
    logic        fifo_empty;
    link_entry_t head;
    link_entry_t push_entry;
    logic        kill_req;
    logic        incept_req;
    logic        accepting;
    logic        present;
    logic        push;
    logic        pop;
    logic        flush;

    assign kill_req   = s_enable & s_kill;
    assign incept_req = s_enable & s_incept;

    // Pushes only in IDLE: DRAIN must empty the FIFO before the incept.
    // Gated by reset so no ack escapes while the link is held in reset.
    assign accepting    = reset & s_enable & ~fifo_full & (state_q == IDLE);
    assign s_send_ack   = accepting & s_send;
    assign s_stream_ack = accepting & s_stream;
    assign push         = s_send_ack | s_stream_ack;

    assign push_entry = '{
        is_stream:       s_stream,
        data:            s_data,
        self_permission: s_self_permission,
        self_address:    s_self_address
    };

    assign present = ~fifo_empty & ((state_q == IDLE) || (state_q == DRAIN));
    // Only the ack matching the presented line pops the head.
    assign pop     = present & (head.is_stream ? r_stream_ack : r_send_ack);
    assign flush   = kill_req & ((state_q == IDLE) || (state_q == DRAIN));

    uarc_link_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (head)
    );

    // Control FSM. Kill beats incept; a kill during DRAIN abandons the
    // pending incept, which is then never acknowledged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            cap_self_perm_q <= '0;
            cap_self_addr_q <= '0;
            cap_inc_perm_q  <= '0;
            cap_inc_addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (kill_req) begin
                        cap_self_perm_q <= s_self_permission;
                        cap_self_addr_q <= s_self_address;
                        state_q         <= KILL_WAIT;
                    end else if (incept_req) begin
                        cap_self_perm_q <= s_self_permission;
                        cap_self_addr_q <= s_self_address;
                        cap_inc_perm_q  <= s_incept_permission;
                        cap_inc_addr_q  <= s_incept_address;
                        state_q         <= fifo_empty ? INCEPT_WAIT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (kill_req) begin
                        cap_self_perm_q <= s_self_permission;
                        cap_self_addr_q <= s_self_address;
                        state_q         <= KILL_WAIT;
                    end else if (fifo_empty) begin
                        state_q <= INCEPT_WAIT;
                    end
                end
                KILL_WAIT:   if (r_kill_ack)   state_q <= KILL_DONE;
                KILL_DONE:   state_q <= IDLE;
                INCEPT_WAIT: if (r_incept_ack) state_q <= INCEPT_DONE;
                INCEPT_DONE: state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

    // Kill/incept strobes are pure decodes of the registered state.
    assign s_kill_ack   = (state_q == KILL_DONE);
    assign s_incept_ack = (state_q == INCEPT_DONE);
    assign r_kill       = (state_q == KILL_WAIT);
    assign r_incept     = (state_q == INCEPT_WAIT);

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        r_enable            = 1'b0;
        r_send              = 1'b0;
        r_stream            = 1'b0;
        r_data              = '0;
        r_self_permission   = '0;
        r_self_address      = '0;
        r_incept_permission = '0;
        r_incept_address    = '0;
        if (present) begin
            r_enable          = 1'b1;
            r_send            = ~head.is_stream;
            r_stream          = head.is_stream;
            r_data            = head.data;
            r_self_permission = head.self_permission;
            r_self_address    = head.self_address;
        end else if (state_q == KILL_WAIT) begin
            r_enable          = 1'b1;
            r_self_permission = cap_self_perm_q;
            r_self_address    = cap_self_addr_q;
        end else if (state_q == INCEPT_WAIT) begin
            r_enable            = 1'b1;
            r_self_permission   = cap_self_perm_q;
            r_self_address      = cap_self_addr_q;
            r_incept_permission = cap_inc_perm_q;
            r_incept_address    = cap_inc_addr_q;
        end
    end

endmodule

// File: tb/tb_uarc_link.sv
// -----------------------------------------------------------------------------
// tb_uarc_link
// Self-checking bench for uarc_link: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level model made of a
// queue of pending words and the current link phase.
// -----------------------------------------------------------------------------
module tb_uarc_link;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_enable, s_kill, s_incept, s_send, s_stream;
    logic [31:0] s_data, s_self_permission, s_self_address;
    logic [31:0] s_incept_permission, s_incept_address;
    logic        s_kill_ack, s_incept_ack, s_send_ack, s_stream_ack;
    logic        r_enable, r_kill, r_incept, r_send, r_stream;
    logic [31:0] r_data, r_self_permission, r_self_address;
    logic [31:0] r_incept_permission, r_incept_address;
    logic        r_kill_ack, r_incept_ack, r_send_ack, r_stream_ack;

    always #5 clk = ~clk;

    uarc_link dut (
        .clk                 (clk),
        .reset               (reset),
        .s_enable            (s_enable),
        .s_kill              (s_kill),
        .s_incept            (s_incept),
        .s_send              (s_send),
        .s_stream            (s_stream),
        .s_data              (s_data),
        .s_self_permission   (s_self_permission),
        .s_self_address      (s_self_address),
        .s_incept_permission (s_incept_permission),
        .s_incept_address    (s_incept_address),
        .s_kill_ack          (s_kill_ack),
        .s_incept_ack        (s_incept_ack),
        .s_send_ack          (s_send_ack),
        .s_stream_ack        (s_stream_ack),
        .r_enable            (r_enable),
        .r_kill              (r_kill),
        .r_incept            (r_incept),
        .r_send              (r_send),
        .r_stream            (r_stream),
        .r_data              (r_data),
        .r_self_permission   (r_self_permission),
        .r_self_address      (r_self_address),
        .r_incept_permission (r_incept_permission),
        .r_incept_address    (r_incept_address),
        .r_kill_ack          (r_kill_ack),
        .r_incept_ack        (r_incept_ack),
        .r_send_ack          (r_send_ack),
        .r_stream_ack        (r_stream_ack)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          st;
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] a;
    } ent_t;

    typedef enum {M_NORMAL, M_DRAIN, M_KILL, M_KILL_ACK, M_INC, M_INC_ACK} mphase_t;

    ent_t        mq[$];
    mphase_t     ph = M_NORMAL;
    logic [31:0] cp, ca, ip, ia;
    logic [31:0] rx[$];   // words the DUT actually handed to the receiver

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit          pres;
        ent_t        h;
        logic [31:0] e_sp, e_sa;
        pres = (ph == M_NORMAL || ph == M_DRAIN) && mq.size() > 0;
        h    = pres ? mq[0] : '{st: 1'b0, d: 32'h0, p: 32'h0, a: 32'h0};
        e_sp = pres ? h.p : ((ph == M_KILL || ph == M_INC) ? cp : 32'h0);
        e_sa = pres ? h.a : ((ph == M_KILL || ph == M_INC) ? ca : 32'h0);
        check("r_enable", r_enable, pres || ph == M_KILL || ph == M_INC);
        check("r_send", r_send, pres && !h.st);
        check("r_stream", r_stream, pres && h.st);
        check("r_kill", r_kill, ph == M_KILL);
        check("r_incept", r_incept, ph == M_INC);
        check("r_data", r_data, pres ? h.d : 32'h0);
        check("r_self_permission", r_self_permission, e_sp);
        check("r_self_address", r_self_address, e_sa);
        check("r_incept_permission", r_incept_permission, ph == M_INC ? ip : 32'h0);
        check("r_incept_address", r_incept_address, ph == M_INC ? ia : 32'h0);
        check("s_kill_ack", s_kill_ack, ph == M_KILL_ACK);
        check("s_incept_ack", s_incept_ack, ph == M_INC_ACK);
        check("s_send_ack", s_send_ack,
              reset && s_enable && s_send && mq.size() < DEPTH && ph == M_NORMAL);
        check("s_stream_ack", s_stream_ack,
              reset && s_enable && s_stream && mq.size() < DEPTH && ph == M_NORMAL);
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_step();
        bit pres, pop, push, kill, inc, was_empty;
        if (!reset) begin
            mq.delete();
            ph = M_NORMAL;
            return;
        end
        was_empty = (mq.size() == 0);
        pres = (ph == M_NORMAL || ph == M_DRAIN) && !was_empty;
        pop  = pres && (mq[0].st ? r_stream_ack : r_send_ack);
        push = s_enable && (s_send || s_stream) && mq.size() < DEPTH && ph == M_NORMAL;
        kill = s_enable && s_kill;
        inc  = s_enable && s_incept && !kill;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{st: s_stream, d: s_data, p: s_self_permission, a: s_self_address});
        case (ph)
            M_NORMAL, M_DRAIN: begin
                if (kill) begin
                    mq.delete();
                    cp = s_self_permission;
                    ca = s_self_address;
                    ph = M_KILL;
                end else if (ph == M_NORMAL && inc) begin
                    cp = s_self_permission;
                    ca = s_self_address;
                    ip = s_incept_permission;
                    ia = s_incept_address;
                    ph = was_empty ? M_INC : M_DRAIN;
                end else if (ph == M_DRAIN && was_empty) begin
                    ph = M_INC;
                end
            end
            M_KILL:     if (r_kill_ack) ph = M_KILL_ACK;
            M_KILL_ACK: ph = M_NORMAL;
            M_INC:      if (r_incept_ack) ph = M_INC_ACK;
            M_INC_ACK:  ph = M_NORMAL;
            default:    ph = M_NORMAL;
        endcase
    endtask

    // One clock: compare just after the input change, then let the edge pass.
    task automatic tick();
        #1;
        compare_outputs();
        if ((r_send && r_send_ack) || (r_stream && r_stream_ack)) rx.push_back(r_data);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s_enable = 1'b0; s_kill = 1'b0; s_incept = 1'b0; s_send = 1'b0; s_stream = 1'b0;
        s_data = '0; s_self_permission = '0; s_self_address = '0;
        s_incept_permission = '0; s_incept_address = '0;
        r_kill_ack = 1'b0; r_incept_ack = 1'b0; r_send_ack = 1'b0; r_stream_ack = 1'b0;
    endtask

    task automatic drain();
        clear_inputs();
        r_send_ack = 1'b1; r_stream_ack = 1'b1; r_kill_ack = 1'b1; r_incept_ack = 1'b1;
        repeat (10) tick();
        clear_inputs();
        rx.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input bit st);
        s_enable = 1'b1; s_send = !st; s_stream = st; s_data = d;
        s_self_permission = d + 32'h1; s_self_address = d + 32'h2;
    endtask

    initial begin
        logic [31:0] exp5[5];
        bit          seen;

        clear_inputs();
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);

        // ---- reset, then reset asserted in the middle of KILL_WAIT ----
        tick();
        reset = 1'b1;
        s_enable = 1'b1; s_kill = 1'b1; s_self_permission = 32'h3; s_self_address = 32'h30;
        tick();
        s_kill = 1'b0;
        #1 check("kill_wait_r_kill", r_kill, 1'b1);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("post_reset_r_enable", r_enable, 1'b0);
        check("post_reset_r_kill", r_kill, 1'b0);
        send_word(32'h5A, 1'b0);
        #1 check("post_reset_send_ack", s_send_ack, 1'b1);
        tick();
        drain();

        // ---- fill to full, refused fifth push, retry after a pop ----
        foreach (exp5[i]) exp5[i] = 32'h11 * (i + 1);
        for (int i = 0; i < 4; i++) begin
            send_word(exp5[i], 1'b0);
            #1 check("fill_send_ack", s_send_ack, 1'b1);
            tick();
        end
        send_word(32'h55, 1'b0);
        #1 check("full_send_ack", s_send_ack, 1'b0);
        tick();
        r_send_ack = 1'b1;
        #1 check("full_pop_send_ack", s_send_ack, 1'b0);
        tick();
        r_send_ack = 1'b0;
        #1 check("retry_send_ack", s_send_ack, 1'b1);
        tick();
        s_send = 1'b0;
        r_send_ack = 1'b1;
        repeat (5) tick();
        check("order_count", rx.size(), 5);
        for (int i = 0; i < 5 && i < rx.size(); i++) check("order_data", rx[i], exp5[i]);
        drain();

        // ---- send / stream interleave, wrong ack does not pop ----
        send_word(32'hA0, 1'b0);
        tick();
        send_word(32'hB0, 1'b1);
        tick();
        clear_inputs();
        r_stream_ack = 1'b1;
        #1;
        check("il_send_line", r_send, 1'b1);
        check("il_send_data", r_data, 32'hA0);
        tick();
        r_stream_ack = 1'b0; r_send_ack = 1'b1;
        #1 check("il_no_pop_data", r_data, 32'hA0);
        tick();
        r_send_ack = 1'b0; r_stream_ack = 1'b1;
        #1;
        check("il_stream_line", r_stream, 1'b1);
        check("il_stream_data", r_data, 32'hB0);
        tick();
        drain();

        // ---- incept drains queued words first; sender drops enable ----
        send_word(32'hC1, 1'b0);
        tick();
        send_word(32'hC2, 1'b0);
        tick();
        clear_inputs();
        s_enable = 1'b1; s_incept = 1'b1;
        s_incept_permission = 32'h7; s_incept_address = 32'h100;
        s_self_permission = 32'h9; s_self_address = 32'h90;
        tick();
        clear_inputs();
        r_send_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1 seen = r_incept;
            if (!seen) tick();
        end
        check("incept_seen", seen, 1'b1);
        check("incept_after_pops", rx.size(), 2);
        check("incept_perm", r_incept_permission, 32'h7);
        check("incept_addr", r_incept_address, 32'h100);
        r_incept_ack = 1'b1;
        tick();
        r_incept_ack = 1'b0;
        #1 check("incept_ack_pulse", s_incept_ack, 1'b1);
        tick();
        #1 check("incept_ack_single", s_incept_ack, 1'b0);
        drain();

        // ---- kill flushes queued words ----
        for (int i = 0; i < 3; i++) begin
            send_word(32'hD0 + i, 1'b0);
            tick();
        end
        clear_inputs();
        s_enable = 1'b1; s_kill = 1'b1; s_self_permission = 32'h4; s_self_address = 32'h44;
        tick();
        #1;
        check("kill_r_kill", r_kill, 1'b1);
        check("kill_no_send", r_send, 1'b0);
        check("kill_self_addr", r_self_address, 32'h44);
        r_kill_ack = 1'b1;
        tick();
        s_kill = 1'b0; r_kill_ack = 1'b0;
        #1 check("kill_ack_pulse", s_kill_ack, 1'b1);
        tick();
        #1;
        check("kill_ack_single", s_kill_ack, 1'b0);
        check("kill_flushed", r_enable, 1'b0);
        drain();

        // ---- depth wrap with simultaneous push and pop at count 1 ----
        send_word(32'hE0, 1'b0);
        tick();
        r_send_ack = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send_word(32'hE0 + i, 1'b0);
            #1 check("wrap_send_ack", s_send_ack, 1'b1);
            tick();
        end
        s_send = 1'b0;
        repeat (3) tick();
        check("wrap_count", rx.size(), 11);
        for (int i = 0; i < 11 && i < rx.size(); i++) check("wrap_data", rx[i], 32'hE0 + i);
        drain();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 2000; c++) begin
            int r;
            clear_inputs();
            reset    = ($urandom_range(0, 199) != 0);
            s_enable = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 19);
            s_kill   = (r == 0);
            s_incept = (r == 1 || r == 2);
            s_send   = (r >= 3 && r <= 9);
            s_stream = (r >= 10 && r <= 13);
            s_data              = $urandom;
            s_self_permission   = $urandom;
            s_self_address      = $urandom;
            s_incept_permission = $urandom;
            s_incept_address    = $urandom;
            r_send_ack   = $urandom_range(0, 1);
            r_stream_ack = $urandom_range(0, 1);
            r_kill_ack   = ($urandom_range(0, 2) == 0);
            r_incept_ack = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
